// File: rtl/shift_add_multiplier_if.sv
// ============================================================================
// Module : shift_add_multiplier_if
// Brief  : Operand/product valid-ready bundle for shift_add_multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface shift_add_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, overflow
  );
endinterface

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ============================================================================
// Module : shift_add_multiplier
// Brief  : Iterative unsigned WIDTHxWIDTH multiplier driving an external adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_add_multiplier #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  shift_add_multiplier_if.slave mul,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  wire logic [WIDTH-1:0] add_sum,
  input  wire logic             add_carryout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_p_hi;
  logic [WIDTH-1:0]     r_p_lo;
  logic [IW-1:0]        r_iter;
  logic [SW-1:0]        r_settle;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_overflow;

  logic                 w_accept;
  logic                 w_step_end;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_p_next;

  assign w_accept   = (r_state == S_IDLE) && mul.in_valid;
  assign w_step_end = (r_state == S_ITER) && (r_settle == SW'(SETTLE_CYCLES - 1));
  assign w_last     = w_step_end && (r_iter == IW'(WIDTH - 1));
  // Carry lands in the top bit: P_hi + M never exceeds WIDTH+1 bits.
  assign w_p_next   = {add_carryout, add_sum, r_p_lo[WIDTH-1:1]};

  assign add_cin      = 1'b0;
  assign mul.product  = r_product;
  assign mul.overflow = r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    mul.in_ready  = 1'b0;
    mul.out_valid = 1'b0;
    add_a         = '0;
    add_b         = '0;
    case (r_state)
      S_IDLE: begin
        mul.in_ready = 1'b1;
        if (mul.in_valid) w_next = S_ITER;
      end
      S_ITER: begin
        add_a = r_p_hi;
        add_b = r_p_lo[0] ? r_m : '0;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        mul.out_valid = 1'b1;
        if (mul.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Visible product/overflow only change when a job completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m        <= '0;
      r_p_hi     <= '0;
      r_p_lo     <= '0;
      r_iter     <= '0;
      r_settle   <= '0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_m      <= mul.a;
      r_p_hi   <= '0;
      r_p_lo   <= mul.b;
      r_iter   <= '0;
      r_settle <= '0;
    end else if (r_state == S_ITER) begin
      if (w_step_end) begin
        {r_p_hi, r_p_lo} <= w_p_next;
        r_settle         <= '0;
        r_iter           <= r_iter + IW'(1);
        if (w_last) begin
          r_product  <= w_p_next;
          r_overflow <= |w_p_next[2*WIDTH-1:WIDTH];
        end
      end else begin
        r_settle <= r_settle + SW'(1);
      end
    end
  end

endmodule

`default_nettype wire
